// File: rtl/selector_scan_ctrl_pkg.sv
// Shared types and constants for the selector scan controller.
// The 7-to-1 selector uses a 3-bit select and a 2-bit FSM state.
// No datapath storage lives here.
package selector_scan_ctrl_pkg;

    localparam int NUM_SEL_IN = 7;
    localparam int SEL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while enabled; tc pulses combinationally on the last count.
// Latency: tc asserted in the same cycle the count reaches DWELL-1.
// No backpressure; clr has priority over en and returns the count to 0.
module scan_dwell_counter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/selector_scan_ctrl.sv
// Drives a pattern onto the 7-to-1 selector, steps its select 0..6 and samples Y; optional SCAN_CHECK_EN adds mismatch.
// Latency: done pulses 2 + 7*DWELL cycles after the accepting start edge.
// No queuing: start is ignored unless IDLE; abort cancels LOAD/SCAN back to IDLE.
module selector_scan_ctrl
    import selector_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_SEL_IN-1:0] pattern,
    output logic [NUM_SEL_IN-1:0] mux_data,
    output logic [SEL_W-1:0]      mux_sel,
    input  logic                  mux_y,
    output logic [NUM_SEL_IN-1:0] captured,
    output logic                  busy,
    output logic                  done
`ifdef SCAN_CHECK_EN
    ,
    output logic                  mismatch
`endif
);

    scan_state_t state;
    logic        dwell_tc;
    logic        last_sel;

    assign last_sel = (mux_sel == SEL_W'(NUM_SEL_IN - 1));

    scan_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clock  (clock),
        .resetn (resetn),
        .en     (state == ST_SCAN),
        .clr    (state != ST_SCAN),
        .tc     (dwell_tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mux_data <= '0;
            mux_sel  <= '0;
            captured <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mux_sel <= '0;
                    if (start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        mux_sel <= '0;
                    end else begin
                        mux_data <= pattern;
                        captured <= '0;
                        mux_sel  <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Abort wins over a coincident sample so the partial word is stable.
                    if (abort) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        mux_sel <= '0;
                    end else if (dwell_tc) begin
                        captured[mux_sel] <= mux_y;
                        if (last_sel) state <= ST_DONE;
                        else          mux_sel <= mux_sel + SEL_W'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    mux_sel <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCAN_CHECK_EN
    // Final sample already landed in captured on the edge that entered DONE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mismatch <= 1'b0;
        end else if (state == ST_LOAD && !abort) begin
            mismatch <= 1'b0;
        end else if (state == ST_DONE) begin
            mismatch <= (captured != mux_data);
        end
    end
`endif

endmodule

// File: tb/tb_selector_scan_ctrl.sv
// Self-checking bench: two controllers (DWELL=4 and DWELL=1) each driving a modelled selector.
module tb_selector_scan_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       abort;
    logic       start4, start1;
    logic       fault_en;
    logic [6:0] pattern;

    logic [6:0] d4_data, d4_cap, d1_data, d1_cap;
    logic [2:0] d4_sel, d1_sel;
    logic       d4_y, d1_y, d4_busy, d1_busy, d4_done, d1_done;
`ifdef SCAN_CHECK_EN
    logic       d4_mismatch, d1_mismatch;
`endif

    int         n_checks = 0;
    int         n_err    = 0;
    logic [6:0] exp_q[$];

    logic [6:0] o_data, o_cap;
    logic [2:0] o_sel;
    logic       o_busy, o_done;
    logic       o_mis   = 1'b0;
    logic       mis_mid = 1'b0;

    always #5 clock = ~clock;

    selector_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut4 (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start4),
        .abort    (abort),
        .pattern  (pattern),
        .mux_data (d4_data),
        .mux_sel  (d4_sel),
        .mux_y    (d4_y),
        .captured (d4_cap),
        .busy     (d4_busy),
        .done     (d4_done)
`ifdef SCAN_CHECK_EN
        ,
        .mismatch (d4_mismatch)
`endif
    );

    selector_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start1),
        .abort    (abort),
        .pattern  (pattern),
        .mux_data (d1_data),
        .mux_sel  (d1_sel),
        .mux_y    (d1_y),
        .captured (d1_cap),
        .busy     (d1_busy),
        .done     (d1_done)
`ifdef SCAN_CHECK_EN
        ,
        .mismatch (d1_mismatch)
`endif
    );

    // Selector models; fault_en sticks input 5 of the DWELL=4 selector at 0.
    always_comb begin
        d4_y = 1'b0;
        for (int i = 0; i < 7; i++)
            if (d4_sel == 3'(i)) d4_y = (fault_en && i == 5) ? 1'b0 : d4_data[i];
    end

    always_comb begin
        d1_y = 1'b0;
        for (int i = 0; i < 7; i++)
            if (d1_sel == 3'(i)) d1_y = d1_data[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic snap(input int which);
        if (which == 0) begin
            o_data = d4_data; o_cap = d4_cap; o_sel = d4_sel; o_busy = d4_busy; o_done = d4_done;
`ifdef SCAN_CHECK_EN
            o_mis = d4_mismatch;
`endif
        end else begin
            o_data = d1_data; o_cap = d1_cap; o_sel = d1_sel; o_busy = d1_busy; o_done = d1_done;
`ifdef SCAN_CHECK_EN
            o_mis = d1_mismatch;
`endif
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start4 = v;
        else            start1 = v;
    endtask

    // One scan: k counts edges after the accepting start edge.
    task automatic run_scan(input int which, input int dw, input logic [6:0] p,
                            input logic [6:0] exp_cap, input int restart_at,
                            input int abort_at, input logic abort_with_start, input string tag);
        int         done_k   = -1;
        int         n_done   = 0;
        int         sel_bad  = 0;
        int         busy_bad = 0;
        int         saw7     = 0;
        int         es;
        logic       eb;
        logic [6:0] got;
        exp_q.push_back(exp_cap);
        pattern = p;
        abort   = abort_with_start;
        set_start(which, 1'b1);
        tick();
        set_start(which, 1'b0);
        abort = 1'b0;
        for (int k = 1; k <= 7 * dw + 8; k++) begin
            tick();
            snap(which);
            if (abort_at >= 0 && k > abort_at) es = 0;
            else if (k <= 7 * dw)              es = (k - 1) / dw;
            else if (k == 7 * dw + 1)          es = 6;
            else                               es = 0;
            if (o_sel !== 3'(es)) sel_bad++;
            if (o_sel === 3'd7) saw7++;
            eb = (abort_at >= 0) ? (k <= abort_at) : (k <= 7 * dw + 1);
            if (o_busy !== eb) busy_bad++;
            if (o_done === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = k;
                got = 'x;
                if (exp_q.size() > 0) got = exp_q.pop_front();
                check({tag, " captured"}, 32'(o_cap), 32'(got));
            end
`ifdef SCAN_CHECK_EN
            if (k == 3) mis_mid = o_mis;
`endif
            if (k == restart_at) begin
                pattern = 7'h7F;
                set_start(which, 1'b1);
            end else begin
                set_start(which, 1'b0);
            end
            abort = (k == abort_at);
        end
        set_start(which, 1'b0);
        abort = 1'b0;
        if (abort_at >= 0) begin
            check({tag, " done count"}, 32'(n_done), 32'd0);
            got = 'x;
            if (exp_q.size() > 0) got = exp_q.pop_front();
            check({tag, " partial captured"}, 32'(o_cap), 32'(got));
        end else begin
            check({tag, " done latency"}, 32'(done_k), 32'(2 + 7 * dw));
            check({tag, " done count"}, 32'(n_done), 32'd1);
        end
        check({tag, " sel sequence"}, 32'(sel_bad), 32'd0);
        check({tag, " sel never 7"}, 32'(saw7), 32'd0);
        check({tag, " busy window"}, 32'(busy_bad), 32'd0);
        check({tag, " mux_data"}, 32'(o_data), 32'(p));
        check({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        abort    = 1'b0;
        start4   = 1'b0;
        start1   = 1'b0;
        fault_en = 1'b0;
        pattern  = 7'h00;
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            snap(w);
            check("reset mux_data", 32'(o_data), 32'd0);
            check("reset mux_sel", 32'(o_sel), 32'd0);
            check("reset captured", 32'(o_cap), 32'd0);
            check("reset busy", 32'(o_busy), 32'd0);
            check("reset done", 32'(o_done), 32'd0);
        end
        resetn = 1'b1;
        tick();

        run_scan(0, 4, 7'b1011001, 7'b1011001, -1, -1, 1'b0, "basic");
        run_scan(1, 1, 7'b0000001, 7'b0000001, -1, -1, 1'b0, "dwell1");
        run_scan(0, 4, 7'b0110101, 7'b0110101, 5, -1, 1'b0, "restart");
        run_scan(0, 4, 7'h7F, 7'b0000111, -1, 14, 1'b0, "abort");

        // Asynchronous reset in the middle of a scan.
        pattern = 7'h7F;
        start4  = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (10) tick();
        snap(0);
        check("pre-reset captured", 32'(o_cap), 32'(7'b0000011));
        check("pre-reset busy", 32'(o_busy), 32'd1);
        #1 resetn = 1'b0;
        #1;
        snap(0);
        check("midreset mux_sel", 32'(o_sel), 32'd0);
        check("midreset busy", 32'(o_busy), 32'd0);
        check("midreset done", 32'(o_done), 32'd0);
        check("midreset captured", 32'(o_cap), 32'd0);
        check("midreset mux_data", 32'(o_data), 32'd0);
        #1 resetn = 1'b1;
        tick();
        snap(0);
        check("postreset busy", 32'(o_busy), 32'd0);
        check("postreset mux_sel", 32'(o_sel), 32'd0);

        run_scan(0, 4, 7'b1100110, 7'b1100110, -1, -1, 1'b1, "start_wins");

        fault_en = 1'b1;
        run_scan(0, 4, 7'h7F, 7'b1011111, -1, -1, 1'b0, "fault");
        fault_en = 1'b0;
`ifdef SCAN_CHECK_EN
        snap(0);
        check("fault mismatch", 32'(o_mis), 32'd1);
`endif
        run_scan(0, 4, 7'b0101010, 7'b0101010, -1, -1, 1'b0, "clean");
`ifdef SCAN_CHECK_EN
        check("load clears mismatch", 32'(mis_mid), 32'd0);
        snap(0);
        check("clean mismatch", 32'(o_mis), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
